// File: rtl/cam_capture.sv
// Camera byte-stream capture: pairs 8-bit bus bytes into pixels, repacks them to DW bits
// and writes them row-major into a frame RAM, with frame gating and line-error status.
module cam_capture #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic [7:0]    CAM_px_data,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [1:0]    mode,
  input  logic          cap_en,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          line_err,
  output logic          busy
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic            vsync_q, href_q;
  logic [1:0]      mode_q, mode_d;
  logic            phase_q, phase_d;
  logic [7:0]      b1_q, b1_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW-1:0]   base_q, base_d;
  logic            regw_q, regw_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            done_q, done_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            lerr_q, lerr_d;
  logic [DW-1:0]   pack_w;
  logic            frame_start, frame_end, href_fall;

  assign frame_start = vsync_q & ~CAM_vsync;
  assign frame_end   = ~vsync_q & CAM_vsync;
  assign href_fall   = href_q & ~CAM_href;

  // Repack {b1, current byte}; mode 3 falls through to RGB444 input.
  generate
    if (DW == 12) begin : g_pack12
      always_comb begin
        case (mode_q)
          2'd1:    pack_w = {b1_q[7:4], b1_q[2:0], CAM_px_data[7], CAM_px_data[4:1]};
          2'd2:    pack_w = {b1_q[6:3], b1_q[1:0], CAM_px_data[7:6], CAM_px_data[4:1]};
          default: pack_w = {b1_q[3:0], CAM_px_data};
        endcase
      end
    end else begin : g_pack8
      always_comb begin
        case (mode_q)
          2'd1:    pack_w = {b1_q[7:5], b1_q[2:0], CAM_px_data[4:3]};
          2'd2:    pack_w = {b1_q[6:4], b1_q[1:0], CAM_px_data[7], CAM_px_data[4:3]};
          default: pack_w = {b1_q[3:1], CAM_px_data[7:5], CAM_px_data[3:2]};
        endcase
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    b1_d    = b1_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    regw_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    lerr_d  = lerr_q;
    case (state_q)
      IDLE: begin
        if (frame_start && cap_en) begin
          state_d = ACTIVE;
          mode_d  = mode;
          phase_d = 1'b0;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
          lerr_d  = 1'b0;
        end
      end
      ACTIVE: begin
        if (CAM_href) begin
          if (!phase_q) begin
            b1_d    = CAM_px_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (col_q < COL_MAX && row_q < ROW_MAX) begin
              regw_d = 1'b1;
              addr_d = base_q + AW'(col_q);
              data_d = pack_w;
            end
            if (col_q < COL_MAX) col_d = col_q + 1'b1;
          end
        end else if (href_fall) begin
          // Lines that never completed a pixel do not consume a row.
          if (col_q != '0) begin
            col_d = '0;
            if (row_q < ROW_MAX) begin
              row_d  = row_q + 1'b1;
              base_d = base_q + ROW_STEP;
            end
          end
          if (phase_q) lerr_d = 1'b1;
          phase_d = 1'b0;
        end
        if (frame_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CAM_pclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vsync_q <= 1'b1;
      href_q  <= 1'b0;
      mode_q  <= 2'd0;
      phase_q <= 1'b0;
      b1_q    <= 8'd0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      regw_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= CAM_vsync;
      href_q  <= CAM_href;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      b1_q    <= b1_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      regw_q  <= regw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      lerr_q  <= lerr_d;
    end
  end

  assign DP_RAM_regW    = regw_q;
  assign DP_RAM_addr_in = addr_q;
  assign DP_RAM_data_in = data_q;
  assign frame_done     = done_q;
  assign frame_cnt      = cnt_q;
  assign line_err       = lerr_q;
  assign busy           = (state_q == ACTIVE);

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture: directed frames plus random frames scored against
// a pixel-level model (RGB component truncation, row-major addressing, clipping).
module tb_cam_capture;

  localparam int AW = 4;
  localparam int DW = 12;
  localparam int W  = 5;
  localparam int H  = 3;

  logic          clk, rst;
  logic [7:0]    px;
  logic          vsync, href;
  logic [1:0]    mode_s;
  logic          cap_en;
  logic          regw;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          fdone;
  logic [7:0]    fcnt;
  logic          lerr;
  logic          busy;

  cam_capture #(.AW(AW), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .CAM_pclk(clk), .rst(rst), .CAM_px_data(px), .CAM_vsync(vsync), .CAM_href(href),
    .mode(mode_s), .cap_en(cap_en), .DP_RAM_regW(regw), .DP_RAM_addr_in(addr),
    .DP_RAM_data_in(data), .frame_done(fdone), .frame_cnt(fcnt), .line_err(lerr), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          done_seen = 0;
  int          exp_done = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic        exp_lerr = 1'b0;
  int          line_bytes[$];
  bit          use_fix = 0;
  bit          verbose = 1;
  logic [7:0]  fix_b1, fix_b2;

  always @(negedge clk) begin
    if (regw === 1'b1) got_q.push_back({addr, data});
    if (fdone === 1'b1) done_seen++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference repack: decode the 16-bit pixel into colour components and keep 4 MSBs each.
  function automatic logic [11:0] ref_pack(input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [1:0] m);
    logic [15:0] w;
    logic [4:0]  r5, g5, b5;
    logic [5:0]  g6;
    logic [11:0] res;
    w = {b1, b2};
    case (m)
      2'd1: begin
        r5 = w[15:11]; g6 = w[10:5]; b5 = w[4:0];
        res = {r5[4:1], g6[5:2], b5[4:1]};
      end
      2'd2: begin
        r5 = w[14:10]; g5 = w[9:5]; b5 = w[4:0];
        res = {r5[4:1], g5[4:1], b5[4:1]};
      end
      default: res = w[11:0];
    endcase
    return res;
  endfunction

  task automatic compare_frame(input string name);
    check({name, "_wr_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({name, "_addr"}, got_q[i][15:12], exp_q[i][15:12]);
      check({name, "_data"}, got_q[i][11:0], exp_q[i][11:0]);
    end
    check({name, "_done_cnt"}, done_seen, exp_done);
    check({name, "_frame_cnt"}, fcnt, exp_cnt);
    check({name, "_line_err"}, lerr, exp_lerr);
    check({name, "_busy_end"}, busy, 1'b0);
    if (verbose)
      $display("frame %s: writes=%0d frame_cnt=%0d line_err=%0b", name, got_q.size(), fcnt, lerr);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input string name, input logic [1:0] m, input logic cap,
                           input bit coincide);
    int row;
    int nb;
    logic [7:0] b1, b2, byte_v;
    b1 = 8'd0;
    vsync = 1'b1; href = 1'b0; mode_s = m; cap_en = cap;
    repeat (2) tick();
    vsync = 1'b0;
    tick();
    // Later mode/cap_en changes must not affect this frame.
    mode_s = 2'($urandom_range(0, 3));
    cap_en = ~cap;
    if (cap) exp_lerr = 1'b0;
    row = 0;
    repeat (2) tick();
    check({name, "_busy_mid"}, busy, cap);
    for (int i = 0; i < line_bytes.size(); i++) begin
      nb = line_bytes[i];
      for (int j = 0; j < nb; j++) begin
        if (use_fix) byte_v = (j % 2 == 0) ? fix_b1 : fix_b2;
        else         byte_v = 8'($urandom);
        if (j % 2 == 0) b1 = byte_v;
        else begin
          b2 = byte_v;
          if (cap && (j / 2) < W && row < H)
            exp_q.push_back({4'(row * W + j / 2), ref_pack(b1, b2, m)});
        end
        href = 1'b1; px = byte_v;
        tick();
      end
      href = 1'b0;
      if (coincide && i == line_bytes.size() - 1) vsync = 1'b1;
      tick();
      if (nb >= 2) row++;
      if (cap && (nb % 2 == 1)) exp_lerr = 1'b1;
      if (!(coincide && i == line_bytes.size() - 1)) repeat (2) tick();
    end
    if (!coincide) begin
      vsync = 1'b1;
      tick();
    end
    repeat (3) tick();
    if (cap) begin
      exp_cnt++;
      exp_done++;
    end
    compare_frame(name);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; px = 8'd0; vsync = 1'b1; href = 1'b0; mode_s = 2'd0; cap_en = 1'b0;
    repeat (2) tick();
    check("rst_regw", regw, 1'b0);
    check("rst_addr", addr, 4'd0);
    check("rst_data", data, 12'd0);
    check("rst_done", fdone, 1'b0);
    check("rst_cnt", fcnt, 8'd0);
    check("rst_lerr", lerr, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // 444, 2x2 pixels of 0x0A,0xBC
    use_fix = 1; fix_b1 = 8'h0A; fix_b2 = 8'hBC;
    line_bytes = '{4, 4};
    run_frame("t1_444", 2'd0, 1'b1, 1'b0);

    fix_b1 = 8'hF8; fix_b2 = 8'h1F;
    line_bytes = '{2};
    run_frame("t2_565", 2'd1, 1'b1, 1'b0);
    fix_b1 = 8'h7C; fix_b2 = 8'h00;
    run_frame("t2_555", 2'd2, 1'b1, 1'b0);
    use_fix = 0;

    for (int f = 0; f < 8; f++) begin
      line_bytes.delete();
      for (int l = 0; l < int'($urandom_range(1, 5)); l++)
        line_bytes.push_back(int'($urandom_range(1, 14)));
      run_frame("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)));
    end

    // clipping: W+5 pixels per line, H+3 lines
    line_bytes = '{20, 20, 20, 20, 20, 20};
    run_frame("t3_clip", 2'd1, 1'b1, 1'b0);

    line_bytes = '{3, 4};
    run_frame("t4_odd", 2'd0, 1'b1, 1'b0);
    line_bytes = '{4};
    run_frame("t4_clear", 2'd2, 1'b1, 1'b0);
    line_bytes = '{4, 5};
    run_frame("t4_coincide", 2'd0, 1'b1, 1'b1);

    line_bytes = '{4, 6};
    run_frame("t5_gated", 2'd0, 1'b0, 1'b0);

    // reset mid-line of a captured frame
    vsync = 1'b1; cap_en = 1'b1; mode_s = 2'd0;
    repeat (2) tick();
    vsync = 1'b0;
    repeat (3) tick();
    for (int j = 0; j < 3; j++) begin
      href = 1'b1; px = 8'($urandom);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    check("t6_async_regw", regw, 1'b0);
    check("t6_async_addr", addr, 4'd0);
    check("t6_async_data", data, 12'd0);
    check("t6_async_cnt", fcnt, 8'd0);
    check("t6_async_lerr", lerr, 1'b0);
    check("t6_async_busy", busy, 1'b0);
    got_q.delete();
    exp_q.delete();
    exp_cnt = 8'd0; exp_lerr = 1'b0;
    cap_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      href = 1'b1; px = 8'($urandom);
      tick();
      cap_en = 1'b1;
    end
    href = 1'b0;
    repeat (3) tick();
    check("t6_no_writes", got_q.size(), 0);
    check("t6_idle_busy", busy, 1'b0);
    $display("reset mid-line: writes after reset=%0d busy=%0b", got_q.size(), busy);

    verbose = 0;
    line_bytes = '{2};
    for (int f = 0; f < 256; f++)
      run_frame("t6_wrap", 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    check("t6_wrap_zero", fcnt, 8'd0);
    $display("after 256 frames: frame_cnt=%0d", fcnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
